// File: rtl/sdram_rom_arbiter.sv
// Shares one toggle-handshake SDRAM word channel among the ROM download
// stream and three read clients, each backed by a one-word cache.
module sdram_rom_arbiter #(
    parameter int AW         = 23,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dl_wr,
    input  logic [AW:0]   dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_busy,
    input  logic [AW-1:0] csd_addr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [AW-1:0] spr_addr,
    output logic [15:0]   csd_q,
    output logic [15:0]   cpu_q,
    output logic [15:0]   spr_q,
    output logic          csd_valid,
    output logic          cpu_valid,
    output logic          spr_valid,
    output logic          mem_req,
    input  logic          mem_ack,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [1:0]    mem_ds,
    output logic [15:0]   mem_d,
    input  logic [15:0]   mem_q
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic { IDLE, ISSUE } state_t;
    typedef enum logic [1:0] { G_DL, G_CSD, G_CPU, G_SPR } gnt_t;

    state_t        state;
    state_t        state_nx;
    gnt_t          gnt;
    gnt_t          gnt_sel;
    logic          grant;
    logic          done;
    logic          chan_idle;
    logic          pending;
    logic [AW:0]   hold_addr;
    logic [7:0]    hold_data;
    logic          dl_req;
    logic [AW:0]   wr_addr;
    logic [7:0]    wr_data;
    logic [AW-1:0] csd_tag;
    logic [AW-1:0] cpu_tag;
    logic [AW-1:0] spr_tag;
    logic [AW-1:0] lat_tag;
    logic [AW-1:0] gnt_addr;
    logic          csd_ok;
    logic          cpu_ok;
    logic          spr_ok;
    logic          csd_miss;
    logic          cpu_miss;
    logic          spr_miss;
    logic          spr_urgent;
    logic [SW-1:0] starve;

    // A byte strobed this cycle is visible to arbitration immediately,
    // so a download always beats a read miss raised in the same cycle.
    assign chan_idle  = (mem_ack == mem_req);
    assign dl_req     = pending | dl_wr;
    assign wr_addr    = dl_wr ? dl_addr : hold_addr;
    assign wr_data    = dl_wr ? dl_data : hold_data;
    assign csd_miss   = !csd_ok || (csd_addr != csd_tag);
    assign cpu_miss   = !cpu_ok || (cpu_addr != cpu_tag);
    assign spr_miss   = !spr_ok || (spr_addr != spr_tag);
    assign csd_valid  = !csd_miss;
    assign cpu_valid  = !cpu_miss;
    assign spr_valid  = !spr_miss;
    assign spr_urgent = spr_miss && (starve >= SW'(STARVE_MAX));
    assign dl_busy    = pending | ((state == ISSUE) & mem_we);

    // Next state and grant selection; arbitration only while idle.
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        done     = 1'b0;
        gnt_sel  = G_DL;
        unique case (state)
            IDLE: begin
                if (chan_idle) begin
                    grant = 1'b1;
                    if (dl_req)          gnt_sel = G_DL;
                    else if (spr_urgent) gnt_sel = G_SPR;
                    else if (csd_miss)   gnt_sel = G_CSD;
                    else if (cpu_miss)   gnt_sel = G_CPU;
                    else if (spr_miss)   gnt_sel = G_SPR;
                    else                 grant   = 1'b0;
                end
                if (grant) state_nx = ISSUE;
            end
            ISSUE: begin
                if (chan_idle) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    // Command word address of the selected client.
    always_comb begin
        gnt_addr = wr_addr[AW:1];
        case (gnt_sel)
            G_CSD:   gnt_addr = csd_addr;
            G_CPU:   gnt_addr = cpu_addr;
            G_SPR:   gnt_addr = spr_addr;
            default: gnt_addr = wr_addr[AW:1];
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Request toggle survives reset so an in-flight command can finish.
    always_ff @(posedge clk) begin
        if (grant && !reset) mem_req <= ~mem_req;
    end

    // Command latch, caches, download holding register, starve counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
            mem_we    <= 1'b0;
            mem_a     <= '0;
            mem_ds    <= 2'b00;
            mem_d     <= '0;
            gnt       <= G_DL;
            lat_tag   <= '0;
            starve    <= '0;
            csd_ok    <= 1'b0;
            cpu_ok    <= 1'b0;
            spr_ok    <= 1'b0;
            csd_tag   <= '0;
            cpu_tag   <= '0;
            spr_tag   <= '0;
            csd_q     <= '0;
            cpu_q     <= '0;
            spr_q     <= '0;
        end else begin
            if (grant) begin
                mem_a   <= gnt_addr;
                mem_we  <= (gnt_sel == G_DL);
                mem_ds  <= (gnt_sel == G_DL) ?
                           {wr_addr[0], ~wr_addr[0]} : 2'b11;
                mem_d   <= {wr_data, wr_data};
                gnt     <= gnt_sel;
                lat_tag <= gnt_addr;
                if (gnt_sel == G_SPR)
                    starve <= '0;
                else if (spr_miss && starve != SW'(STARVE_MAX))
                    starve <= starve + SW'(1);
            end
            if (done) begin
                if (mem_we) begin
                    pending <= 1'b0;
                    csd_ok  <= 1'b0;
                    cpu_ok  <= 1'b0;
                    spr_ok  <= 1'b0;
                end else begin
                    case (gnt)
                        G_CSD: begin
                            csd_q   <= mem_q;
                            csd_tag <= lat_tag;
                            csd_ok  <= (csd_addr == lat_tag);
                        end
                        G_CPU: begin
                            cpu_q   <= mem_q;
                            cpu_tag <= lat_tag;
                            cpu_ok  <= (cpu_addr == lat_tag);
                        end
                        G_SPR: begin
                            spr_q   <= mem_q;
                            spr_tag <= lat_tag;
                            spr_ok  <= (spr_addr == lat_tag);
                        end
                        default: ;
                    endcase
                end
            end
            if (dl_wr) begin
                pending   <= 1'b1;
                hold_addr <= dl_addr;
                hold_data <= dl_data;
            end
        end
    end

    // A download byte must not arrive while the previous one is held.
    assert property (@(posedge clk) disable iff (reset) !(dl_wr && pending));

endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// Scoreboard bench for sdram_rom_arbiter: expected commands are queued
// with the stimulus and checked as mem_req toggles.
module tb_sdram_rom_arbiter;
    localparam int AW = 23;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [1:0]    ds;
        logic [15:0]   d;
    } cmd_t;

    logic          clk;
    logic          reset;
    logic          dl_wr;
    logic [AW:0]   dl_addr;
    logic [7:0]    dl_data;
    logic          dl_busy;
    logic [AW-1:0] csd_addr;
    logic [AW-1:0] cpu_addr;
    logic [AW-1:0] spr_addr;
    logic [15:0]   csd_q;
    logic [15:0]   cpu_q;
    logic [15:0]   spr_q;
    logic          csd_valid;
    logic          cpu_valid;
    logic          spr_valid;
    logic          mem_req;
    logic          mem_ack;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [1:0]    mem_ds;
    logic [15:0]   mem_d;
    logic [15:0]   mem_q;

    cmd_t exp_q[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   lat     = 4;
    int   tog_cnt = 0;
    int   tog_cyc = 0;
    int   gap     = 0;
    int   snap    = 0;
    logic req_snap;

    sdram_rom_arbiter #(.AW(AW), .STARVE_MAX(3)) dut (
        .clk(clk), .reset(reset),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_busy(dl_busy),
        .csd_addr(csd_addr), .cpu_addr(cpu_addr), .spr_addr(spr_addr),
        .csd_q(csd_q), .cpu_q(cpu_q), .spr_q(spr_q),
        .csd_valid(csd_valid), .cpu_valid(cpu_valid),
        .spr_valid(spr_valid),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we),
        .mem_a(mem_a), .mem_ds(mem_ds), .mem_d(mem_d), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] data_of(input logic [AW-1:0] a);
        return (a == 23'h10) ? 16'h1234 : (a[15:0] ^ 16'hC3A5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_rd(input logic [AW-1:0] a);
        cmd_t e;
        e.we = 1'b0; e.a = a; e.ds = 2'b11; e.d = 16'h0;
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [1:0] ds,
                           input logic [15:0] d);
        cmd_t e;
        e.we = 1'b1; e.a = a; e.ds = ds; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_quiet(input int maxc);
        int q;
        q = 0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0 && mem_req === mem_ack) q++;
            else q = 0;
            if (q >= 3) return;
        end
        chk("timeout_quiet", 32'(q), 32'd3);
    endtask

    task automatic wait_tog(input int maxc);
        int t0;
        t0 = tog_cnt;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk); #2;
            if (tog_cnt != t0) return;
        end
        chk("timeout_tog", 32'(tog_cnt - t0), 32'd1);
    endtask

    task automatic wait_ack(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk); #2;
            if (mem_req === mem_ack) return;
        end
        chk("timeout_ack", 32'(mem_req === mem_ack), 32'd1);
    endtask

    // Command monitor: pops the scoreboard on every mem_req toggle.
    initial begin : mon
        logic prev;
        cmd_t e;
        #1 prev = mem_req;
        forever begin
            @(posedge clk); #1;
            if (mem_req !== prev) begin
                prev = mem_req;
                tog_cnt++;
                gap     = cyc - tog_cyc;
                tog_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", 32'(mem_a), 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_we", 32'(mem_we), 32'(e.we));
                    chk("cmd_a", 32'(mem_a), 32'(e.a));
                    chk("cmd_ds", 32'(mem_ds), 32'(e.ds));
                    if (e.we) chk("cmd_d", 32'(mem_d), 32'(e.d));
                end
            end
        end
    end

    // SDRAM model: acknowledges lat negedges after a new command.
    initial begin : resp
        int cnt;
        cnt     = 0;
        mem_ack = 1'b0;
        mem_q   = 16'h0;
        forever begin
            @(negedge clk);
            if (mem_req !== mem_ack) begin
                if (cnt >= lat - 1) begin
                    mem_q   = mem_we ? 16'h0 : data_of(mem_a);
                    mem_ack = mem_req;
                    cnt     = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        reset    = 1'b1;
        dl_wr    = 1'b0;
        dl_addr  = '0;
        dl_data  = 8'h0;
        csd_addr = 23'h0;
        cpu_addr = 23'h10;
        spr_addr = 23'h40;
        repeat (3) @(negedge clk);
        chk("rst_valids", 32'({csd_valid, cpu_valid, spr_valid}), 32'd0);
        chk("rst_q_csd_cpu", {csd_q, cpu_q}, 32'd0);
        chk("rst_q_spr", 32'(spr_q), 32'd0);
        chk("rst_busy_we", 32'({dl_busy, mem_we}), 32'd0);

        // 1: cold caches fill in priority order, then stay quiet
        push_rd(23'h0);
        push_rd(23'h10);
        push_rd(23'h40);
        reset = 1'b0;
        wait_quiet(200);
        chk("t1_cpu_q", 32'(cpu_q), 32'h1234);
        chk("t1_cpu_valid", 32'(cpu_valid), 32'd1);
        chk("t1_csd_q", 32'(csd_q), 32'(data_of(23'h0)));
        chk("t1_spr_q", 32'(spr_q), 32'(data_of(23'h40)));
        snap = tog_cnt;
        repeat (20) @(negedge clk);
        chk("t1_hold_toggles", 32'(tog_cnt), 32'(snap));

        // 2: simultaneous csd and cpu misses
        @(negedge clk);
        csd_addr = 23'h100;
        cpu_addr = 23'h200;
        push_rd(23'h100);
        push_rd(23'h200);
        wait_quiet(200);
        chk("t2_gap", 32'(gap), 32'(lat + 1));
        chk("t2_csd_q", 32'(csd_q), 32'(data_of(23'h100)));
        chk("t2_cpu_q", 32'(cpu_q), 32'(data_of(23'h200)));

        // 3: download write beats a csd miss, then invalidates caches
        @(negedge clk);
        dl_wr    = 1'b1;
        dl_addr  = 24'h020001;
        dl_data  = 8'hA5;
        csd_addr = 23'h300;
        push_wr(23'h10000, 2'b10, 16'hA5A5);
        push_rd(23'h300);
        push_rd(23'h200);
        push_rd(23'h40);
        @(negedge clk);
        dl_wr = 1'b0;
        chk("t3_busy", 32'(dl_busy), 32'd1);
        wait_ack(50);
        chk("t3_busy_clr", 32'(dl_busy), 32'd0);
        chk("t3_valids_clr", 32'({csd_valid, cpu_valid, spr_valid}), 32'd0);
        wait_quiet(300);
        chk("t3_csd_q", 32'(csd_q), 32'(data_of(23'h300)));
        chk("t3_valids", 32'({csd_valid, cpu_valid, spr_valid}), 32'd7);

        // 4: csd keeps missing; spr must win by the 4th grant
        @(negedge clk);
        spr_addr = 23'h500;
        csd_addr = 23'h600;
        cpu_addr = 23'h700;
        push_rd(23'h600);
        push_rd(23'h601);
        push_rd(23'h602);
        push_rd(23'h500);
        push_rd(23'h603);
        push_rd(23'h700);
        for (int k = 0; k < 3; k++) begin
            wait_tog(50);
            wait_ack(50);
            @(negedge clk);
            csd_addr = csd_addr + 23'h1;
        end
        wait_quiet(300);
        chk("t4_spr_q", 32'(spr_q), 32'(data_of(23'h500)));
        chk("t4_csd_q", 32'(csd_q), 32'(data_of(23'h603)));
        chk("t4_valids", 32'({csd_valid, cpu_valid, spr_valid}), 32'd7);

        // 5: address moves while its read is in flight
        @(negedge clk);
        cpu_addr = 23'h800;
        push_rd(23'h800);
        push_rd(23'h900);
        wait_tog(50);
        @(negedge clk);
        cpu_addr = 23'h900;
        wait_ack(50);
        chk("t5_stale_q", 32'(cpu_q), 32'(data_of(23'h800)));
        chk("t5_stale_valid", 32'(cpu_valid), 32'd0);
        wait_quiet(200);
        chk("t5_cpu_q", 32'(cpu_q), 32'(data_of(23'h900)));
        chk("t5_cpu_valid", 32'(cpu_valid), 32'd1);

        // 6: reset during ISSUE, ack lands two cycles after release
        lat = 5;
        @(negedge clk);
        cpu_addr = 23'hA00;
        push_rd(23'hA00);
        wait_tog(50);
        req_snap = mem_req;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_rd(23'h603);
        push_rd(23'hA00);
        push_rd(23'h500);
        @(posedge clk); #2;
        chk("t6_valids", 32'({csd_valid, cpu_valid, spr_valid}), 32'd0);
        chk("t6_cpu_q", 32'(cpu_q), 32'd0);
        chk("t6_no_cmd_a", 32'(mem_req), 32'(req_snap));
        @(posedge clk); #2;
        chk("t6_no_cmd_b", 32'(mem_req), 32'(req_snap));
        chk("t6_ack_late", 32'(mem_req !== mem_ack), 32'd1);
        wait_quiet(300);
        chk("t6_valids_fill", 32'({csd_valid, cpu_valid, spr_valid}), 32'd7);
        chk("t6_cpu_q_fill", 32'(cpu_q), 32'(data_of(23'hA00)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
